// File: rtl/ledr_pwm_pio.sv
// Avalon-MM LED peripheral: NUM_CH outputs, each static, PWM, blink or blink-gated PWM.
// Shared prescaler / PWM frame / blink counters run free; per-channel duty is double-buffered.

// One LED channel: duty shadow + active copy swapped at frame end, and the registered mode mux.
module ledr_pwm_ch #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_i,
  input  logic [PWM_BITS-1:0] wdata_i,
  input  logic                frame_end_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic [1:0]          mode_i,
  input  logic                out_i,
  input  logic                phase_i,
  output logic [PWM_BITS-1:0] shadow_o,
  output logic                led_o
);
  logic [PWM_BITS-1:0] shadow_q, shadow_d, act_q, act_d;
  logic                led_q, led_d, pwm_on;

  // Next shadow/active duty; a write landing on frame end is taken into that frame.
  always_comb begin
    shadow_d = wr_i ? wdata_i : shadow_q;
    act_d    = frame_end_i ? shadow_d : act_q;
    pwm_on   = (pwm_cnt_i < act_q);
    case (mode_i)
      2'b00:   led_d = out_i;
      2'b01:   led_d = pwm_on;
      2'b10:   led_d = phase_i;
      default: led_d = phase_i & pwm_on;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      act_q    <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
      led_q    <= led_d;
    end
  end

  assign shadow_o = shadow_q;
  assign led_o    = led_q;
endmodule

module ledr_pwm_pio #(
  parameter int NUM_CH   = 10,
  parameter int PWM_BITS = 8,
  parameter int PRESC_W  = 16,
  parameter int BLINK_W  = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [4:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] ledr_export
);
  logic [NUM_CH-1:0]                out_q, out_d;
  logic [2*NUM_CH-1:0]              mode_q, mode_d;
  logic [PRESC_W-1:0]               presc_q, presc_d, presc_cnt_q, presc_cnt_d;
  logic [BLINK_W-1:0]               blink_q, blink_d, blink_cnt_q, blink_cnt_d, blink_lim;
  logic                             blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0]              pwm_cnt_q, pwm_cnt_d;
  logic                             tick, frame_end;
  logic                             wr_out, wr_mode, wr_presc, wr_blink;
  logic [NUM_CH-1:0]                wr_duty;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  shadow;
  logic [31:0]                      rdata_q, rdata_d;
  logic                             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Register write decode and control register next state.
  always_comb begin
    wr_out   = avs_write && (avs_address == 5'd0);
    wr_mode  = avs_write && (avs_address == 5'd1);
    wr_presc = avs_write && (avs_address == 5'd2);
    wr_blink = avs_write && (avs_address == 5'd3);
    out_d    = wr_out   ? avs_writedata[NUM_CH-1:0]   : out_q;
    mode_d   = wr_mode  ? avs_writedata[2*NUM_CH-1:0] : mode_q;
    presc_d  = wr_presc ? avs_writedata[PRESC_W-1:0]  : presc_q;
    blink_d  = wr_blink ? avs_writedata[BLINK_W-1:0]  : blink_q;
  end

  // Free-running prescaler, PWM frame counter and blink phase.
  always_comb begin
    tick          = (presc_cnt_q == presc_q);
    frame_end     = tick && (pwm_cnt_q == '1);
    presc_cnt_d   = (wr_presc || tick) ? '0 : presc_cnt_q + PRESC_W'(1);
    pwm_cnt_d     = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    blink_lim     = (blink_q == '0) ? BLINK_W'(1) : blink_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      // >= so a limit lowered below the running count still wraps on the next frame end
      if (blink_cnt_q >= blink_lim - BLINK_W'(1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Read mux sampled on avs_read; registers' pre-write values are returned.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        5'd0:    rdata_d = 32'(out_q);
        5'd1:    rdata_d = 32'(mode_q);
        5'd2:    rdata_d = 32'(presc_q);
        5'd3:    rdata_d = 32'(blink_q);
        default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++)
        if (avs_address == 5'(4 + c)) rdata_d = 32'(shadow[c]);
    end
  end

  // Shared state registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q         <= '0;
      mode_q        <= '0;
      presc_q       <= '0;
      blink_q       <= '0;
      presc_cnt_q   <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      out_q         <= out_d;
      mode_q        <= mode_d;
      presc_q       <= presc_d;
      blink_q       <= blink_d;
      presc_cnt_q   <= presc_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      rdata_q       <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_duty[c] = avs_write && (avs_address == 5'(4 + c));
    ledr_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk_i       (clk_clk),
      .rst_ni      (reset_reset_n),
      .wr_i        (wr_duty[c]),
      .wdata_i     (avs_writedata[PWM_BITS-1:0]),
      .frame_end_i (frame_end),
      .pwm_cnt_i   (pwm_cnt_q),
      .mode_i      (mode_q[2*c +: 2]),
      .out_i       (out_q[c]),
      .phase_i     (blink_phase_q),
      .shadow_o    (shadow[c]),
      .led_o       (ledr_export[c])
    );
  end
endmodule

// File: tb/tb_ledr_pwm_pio.sv
// Random bus traffic against a closed-form reference: counter values are derived from the
// number of clocks since the PRESC write that opens each run, expectations go into queues
// and a negedge monitor compares them as the DUT presents readdata / LED outputs.
module tb_ledr_pwm_pio;
  localparam int NUM_CH   = 10;
  localparam int PWM_BITS = 8;
  localparam int PRESC_W  = 16;
  localparam int BLINK_W  = 8;
  localparam int FR       = 1 << PWM_BITS;
  localparam logic [31:0] OUT_M   = 32'((64'd1 << NUM_CH) - 64'd1);
  localparam logic [31:0] MODE_M  = 32'((64'd1 << (2*NUM_CH)) - 64'd1);
  localparam logic [31:0] PRESC_M = 32'((64'd1 << PRESC_W) - 64'd1);
  localparam logic [31:0] BLINK_M = 32'((64'd1 << BLINK_W) - 64'd1);
  localparam logic [31:0] DUTY_M  = 32'((64'd1 << PWM_BITS) - 64'd1);

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [4:0]        avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata, avs_readdata;
  logic [NUM_CH-1:0] ledr_export;

  ledr_pwm_pio #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESC_W(PRESC_W), .BLINK_W(BLINK_W)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .ledr_export   (ledr_export)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct { int unsigned id; logic [31:0] val; } exp_t;
  exp_t        led_q[$];
  exp_t        rd_q[$];
  exp_t        mon_it;
  int unsigned pcnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // reference state: register file, duty in effect, prescale/blink of this run, clock index
  logic [31:0] m_out, m_mode, m_presc, m_blink;
  logic [31:0] m_shadow[NUM_CH];
  logic [31:0] m_act[NUM_CH];
  int          p, L, e;

  always @(posedge clk_clk) pcnt <= pcnt + 1;

  // monitor: items are tagged with the posedge index after which the DUT must show them
  always @(negedge clk_clk) begin
    while (led_q.size() > 0 && led_q[0].id <= pcnt) begin
      mon_it = led_q.pop_front();
      n_cmp++;
      if (mon_it.id != pcnt || ledr_export !== mon_it.val[NUM_CH-1:0]) begin
        n_bad++;
        $display("FAIL ledr edge=%0d got=%h exp=%h", mon_it.id, ledr_export, mon_it.val[NUM_CH-1:0]);
      end
    end
    while (rd_q.size() > 0 && rd_q[0].id <= pcnt) begin
      mon_it = rd_q.pop_front();
      n_cmp++;
      if (mon_it.id != pcnt || avs_readdata !== mon_it.val) begin
        n_bad++;
        $display("FAIL readdata edge=%0d got=%h exp=%h", mon_it.id, avs_readdata, mon_it.val);
      end
    end
  end

  // Clock k of a run: tick count through k is k/(p+1)+1 (clock 0 ticks from the reset PRESC=0).
  function automatic bit is_fe(int k);
    return (k % (p + 1) == 0) && (((k / (p + 1)) + 1) % FR == 0);
  endfunction

  function automatic logic [NUM_CH-1:0] led_model(int k);
    logic [NUM_CH-1:0] r;
    int  t, pwm, f;
    bit  ph, on;
    t   = k / (p + 1) + 1;
    pwm = t % FR;
    f   = t / FR;
    ph  = ((f / L) % 2) == 1;
    for (int c = 0; c < NUM_CH; c++) begin
      on = pwm < int'(m_act[c]);
      case (m_mode[2*c +: 2])
        2'b00:   r[c] = m_out[c];
        2'b01:   r[c] = on;
        2'b10:   r[c] = ph;
        default: r[c] = ph && on;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_model(logic [4:0] a);
    if (a == 5'd0) return m_out;
    if (a == 5'd1) return m_mode;
    if (a == 5'd2) return m_presc;
    if (a == 5'd3) return m_blink;
    if (int'(a) >= 4 && int'(a) < 4 + NUM_CH) return m_shadow[int'(a) - 4];
    return 32'h0;
  endfunction

  task automatic mwrite(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) m_out = d & OUT_M;
    else if (a == 5'd1) m_mode = d & MODE_M;
    else if (a == 5'd2) m_presc = d & PRESC_M;
    else if (a == 5'd3) m_blink = d & BLINK_M;
    else if (int'(a) < 4 + NUM_CH) m_shadow[int'(a) - 4] = d & DUTY_M;
  endtask

  task automatic model_clear();
    m_out = 0; m_mode = 0; m_presc = 0; m_blink = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = 0;
      m_act[c]    = 0;
    end
    e = 0;
  endtask

  // drive one bus cycle (called at a negedge), queue expectations, advance to next negedge
  task automatic step(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] d);
    exp_t it;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    if (rd) begin
      it.id = pcnt + 1; it.val = rd_model(a);
      rd_q.push_back(it);
    end
    if (wr) mwrite(a, d);
    if (is_fe(e))
      for (int c = 0; c < NUM_CH; c++) m_act[c] = m_shadow[c];
    it.id = pcnt + 2; it.val = 32'(led_model(e));
    led_q.push_back(it);
    e++;
    @(negedge clk_clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // async reset mid-cycle while LEDs are lit, then release on a negedge
  task automatic reset_pulse();
    #2 reset_reset_n = 1'b0;
    #1;
    chk("reset_ledr_async", 32'(ledr_export), 32'h0);
    chk("reset_rdata_async", avs_readdata, 32'h0);
    @(negedge clk_clk);
    @(negedge clk_clk);
    chk("reset_ledr_held", 32'(ledr_export), 32'h0);
    reset_reset_n = 1'b1;
    model_clear();
  endtask

  task automatic run_epoch(input int pp, input int bb, input int n);
    logic [31:0] d;
    logic [4:0]  a;
    logic        rd, wr;
    int          k;
    p = pp;
    L = (bb == 0) ? 1 : bb;
    d = $urandom(); d[15:0] = 16'(pp);
    step(1'b1, 1'b1, 5'd2, d);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 5'(i), $urandom());
    d = $urandom(); d[7:0] = 8'(bb);
    step(1'b1, 1'b1, 5'd3, d);
    while (e < n - 3) begin
      rd = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      d  = $urandom();
      wr = 1'b0;
      if ($urandom_range(0, 15) < 2 || is_fe(e)) begin
        wr = 1'b1;
        k  = $urandom_range(0, 29);
        a  = (k < 2) ? 5'(k) : 5'(k + 2);
        if (is_fe(e)) a = 5'(4 + $urandom_range(0, NUM_CH - 1));
        if (int'(a) >= 4 && int'(a) < 4 + NUM_CH)
          case ($urandom_range(0, 4))
            0: d = 32'h0;
            1: d = 32'(FR - 1);
            2: d = 32'd64;
            3: d = 32'd128;
            default: ;
          endcase
      end
      step(rd, wr, a, d);
    end
    step(1'b1, 1'b1, 5'd1, 32'h0);
    step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 5'd0, 32'h0);
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    @(negedge clk_clk);
    reset_pulse();
  endtask

  initial begin
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    chk("por_ledr", 32'(ledr_export), 32'h0);
    chk("por_rdata", avs_readdata, 32'h0);
    reset_reset_n = 1'b1;
    model_clear();
    run_epoch(0, 2, 3000);
    run_epoch(0, 0, 2000);
    run_epoch(3, 1, 5000);
    run_epoch(1, 3, 3000);
    run_epoch($urandom_range(0, 3), $urandom_range(0, 3), 3000);
    n_cmp++;
    if (led_q.size() != 0 || rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL queues_drained led=%0d rd=%0d exp=0", led_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
